// File: rtl/popcount_packet_scheduler_pkg.sv
// Shared types and width helpers for the popcount packet scheduler.
// Holds the arbiter state, the word tag and the derived-width functions.
package popcount_packet_scheduler_pkg;

  localparam int ID_W     = 4;
  localparam int CNT_PIPE = 16;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            last;
  } tag_t;

  function automatic int calc_sum_w(
    input int width,
    input int max_words
  );
    return $clog2(width * max_words) + 1;
  endfunction

  function automatic int calc_latency(input int width);
    return (width <= 24) ? 1 : 3;
  endfunction

endpackage

// File: rtl/popcount_packet_scheduler_counter.sv
// Pipelined population counter shared by all requesters.
// Counts SIZE_PIPELINE-bit chunks first, then sums them.
module bit_population_counter #(
  parameter  int WIDTH         = 32,
  parameter  int LATENCY       = 3,
  parameter  int SIZE_PIPELINE = 16,
  localparam int CNT_W         = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int NCH   = (WIDTH + SIZE_PIPELINE - 1) / SIZE_PIPELINE;
  localparam int CW    = $clog2(SIZE_PIPELINE + 1);
  localparam int PAD_W = NCH * SIZE_PIPELINE;

  logic [PAD_W-1:0] pad;
  logic [CW-1:0]    chunk_d [NCH];

  assign pad = PAD_W'(data_i);

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      chunk_d[c] = '0;
      for (int b = 0; b < SIZE_PIPELINE; b++) begin
        chunk_d[c] = chunk_d[c] + CW'(pad[c*SIZE_PIPELINE+b]);
      end
    end
  end

  if (LATENCY == 1) begin : g_one
    logic [CNT_W-1:0] sum_d;
    logic [CNT_W-1:0] sum_q;

    always_comb begin
      sum_d = '0;
      for (int c = 0; c < NCH; c++) begin
        sum_d = sum_d + CNT_W'(chunk_d[c]);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) sum_q <= '0;
      else       sum_q <= sum_d;
    end

    assign cnt_o = sum_q;
  end else begin : g_deep
    logic [CW-1:0]    chunk_q [NCH];
    logic [CNT_W-1:0] sum_d;
    logic [CNT_W-1:0] dly_q [LATENCY-1];

    always_comb begin
      sum_d = '0;
      for (int c = 0; c < NCH; c++) begin
        sum_d = sum_d + CNT_W'(chunk_q[c]);
      end
    end

    // Stages past the adder only add delay up to LATENCY.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int c = 0; c < NCH; c++) chunk_q[c] <= '0;
        for (int i = 0; i < LATENCY-1; i++) dly_q[i] <= '0;
      end else begin
        for (int c = 0; c < NCH; c++) chunk_q[c] <= chunk_d[c];
        dly_q[0] <= sum_d;
        for (int i = 1; i < LATENCY-1; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign cnt_o = dly_q[LATENCY-2];
  end

endmodule

// File: rtl/popcount_packet_scheduler.sv
// Round-robin packet arbiter feeding a shared popcount pipeline.
// Sums set bits per packet and reports one result per packet.
module popcount_packet_scheduler
  import popcount_packet_scheduler_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_WORDS = 64,
  parameter  int LATENCY   = calc_latency(WIDTH),
  localparam int SUM_W     = calc_sum_w(WIDTH, MAX_WORDS),
  localparam int IDW       = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]       req_val_i,
  input  logic [N_REQ-1:0]       req_last_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [SUM_W-1:0]       res_sum_o,
  output logic [IDW-1:0]         res_id_o,
  output logic                   res_val_o
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int SUM_W1 = SUM_W + 1;

  state_e           state_q;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   gnt_q;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   ptr_nxt;
  logic [N_REQ-1:0] rdy_q;
  logic             hs;
  logic [WIDTH-1:0] words [N_REQ];
  logic [WIDTH-1:0] data_q;
  tag_t             tag_d;
  tag_t             tag_q [LATENCY+1];
  tag_t             tag_a;
  logic [CNT_W-1:0] cnt;
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W:0]   add_w;
  logic [SUM_W-1:0] add_sat;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = req_data_i[i*WIDTH +: WIDTH];
    end
  end

  // Walk downward so the lowest offset from ptr wins.
  always_comb begin
    pick = ptr_q;
    idx  = ptr_q;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = IDW'((int'(ptr_q) + i) % N_REQ);
      if (req_val_i[idx]) pick = idx;
    end
  end

  assign hs      = rdy_q[gnt_q] & req_val_i[gnt_q];
  assign ptr_nxt = (int'(gnt_q) == N_REQ-1) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      rdy_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|req_val_i) begin
            gnt_q   <= pick;
            rdy_q   <= N_REQ'(1) << pick;
            state_q <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          if (hs && req_last_i[gnt_q]) begin
            rdy_q   <= '0;
            ptr_q   <= ptr_nxt;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = rdy_q;

  always_comb begin
    tag_d       = '0;
    tag_d.valid = hs;
    tag_d.id    = ID_W'(gnt_q);
    tag_d.last  = req_last_i[gnt_q];
  end

  always_ff @(posedge clk_i) begin
    data_q <= words[gnt_q];
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  bit_population_counter #(
    .WIDTH         (WIDTH),
    .LATENCY       (LATENCY),
    .SIZE_PIPELINE (CNT_PIPE)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (arst_i),
    .data_i (data_q),
    .cnt_o  (cnt)
  );

  assign tag_a   = tag_q[LATENCY];
  assign add_w   = {1'b0, acc_q} + SUM_W1'(cnt);
  assign add_sat = add_w[SUM_W] ? '1 : add_w[SUM_W-1:0];

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      acc_q     <= '0;
      res_sum_o <= '0;
      res_id_o  <= '0;
      res_val_o <= 1'b0;
    end else begin
      res_val_o <= 1'b0;
      if (tag_a.valid) begin
        if (tag_a.last) begin
          res_sum_o <= add_sat;
          res_id_o  <= IDW'(tag_a.id);
          res_val_o <= 1'b1;
          acc_q     <= '0;
        end else begin
          acc_q <= add_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_packet_scheduler.sv
// Bench for popcount_packet_scheduler: directed scenarios plus random
// packets checked against a cycle-level scoreboard of the arbitration rules.
module tb_popcount_packet_scheduler;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 3;
  localparam int SW  = 12;
  localparam int SSW = 7;
  localparam int MAXS = 4095;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           arst = 1'b0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   val  = '0;
  logic [N-1:0]   last = '0;
  logic [N-1:0]   rdy;
  logic [SW-1:0]  rsum;
  logic [1:0]     rid;
  logic           rval;

  logic [N*W-1:0] s_data  = '0;
  logic [N-1:0]   s_valv  = '0;
  logic [N-1:0]   s_lastv = '0;
  logic [N-1:0]   s_rdy;
  logic [SSW-1:0] s_sum;
  logic [1:0]     s_id;
  logic           s_rval;

  popcount_packet_scheduler dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_data_i  (data),
    .req_val_i   (val),
    .req_last_i  (last),
    .req_ready_o (rdy),
    .res_sum_o   (rsum),
    .res_id_o    (rid),
    .res_val_o   (rval)
  );

  popcount_packet_scheduler #(.MAX_WORDS(2)) dut_s (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_data_i  (s_data),
    .req_val_i   (s_valv),
    .req_last_i  (s_lastv),
    .req_ready_o (s_rdy),
    .res_sum_o   (s_sum),
    .res_id_o    (s_id),
    .res_val_o   (s_rval)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int due;
    int id;
    int sum;
  } exp_t;

  logic [31:0] sw_d [N][128];
  bit          sw_l [N][128];
  int          hd [N];
  int          tl [N];

  bit   m_locked;
  int   m_gnt, m_ptr, m_total, m_sum, m_id;
  exp_t rq[$];
  int   gnt_log[$];
  int   lock_cyc[$];
  int   p_sum[$];
  int   p_id[$];
  int   s_sums[$];
  int   s_ids[$];
  bit   s_hs;
  int   prob = 100;
  logic [N-1:0] en_mask = '1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [31:0] d, input bit l);
    sw_d[r][tl[r]] = d;
    sw_l[r][tl[r]] = l;
    tl[r]++;
  endtask

  function automatic bit drained();
    bit ok;
    ok = !m_locked && (rq.size() == 0);
    for (int r = 0; r < N; r++) if (hd[r] != tl[r]) ok = 0;
    return ok;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] er;
    exp_t         e;
    bit           ep;
    bit           found;
    er = m_locked ? N'(1 << m_gnt) : '0;
    chk("ready", 64'(rdy), 64'(er));
    ep = (rq.size() > 0) && (rq[0].due == cyc);
    chk("res_val", 64'(rval), 64'(ep));
    if (ep) begin
      e     = rq.pop_front();
      m_sum = e.sum;
      m_id  = e.id;
    end
    chk("res_sum", 64'(rsum), 64'(m_sum));
    chk("res_id", 64'(rid), 64'(m_id));
    if (rval === 1'b1) begin
      p_sum.push_back(int'(rsum));
      p_id.push_back(int'(rid));
    end
    if (s_rval === 1'b1) begin
      s_sums.push_back(int'(s_sum));
      s_ids.push_back(int'(s_id));
    end
    s_hs = s_valv[0] & s_rdy[0];
    if (m_locked) begin
      if (val[m_gnt]) begin
        m_total += $countones(data[m_gnt*W +: W]);
        if (last[m_gnt]) begin
          e.due = cyc + LAT + 2;
          e.id  = m_gnt;
          e.sum = (m_total > MAXS) ? MAXS : m_total;
          rq.push_back(e);
          m_total  = 0;
          m_locked = 0;
          m_ptr    = (m_gnt + 1) % N;
        end
      end
    end else if (|val) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && val[(m_ptr + i) % N]) begin
          m_gnt = (m_ptr + i) % N;
          found = 1;
        end
      end
      m_locked = 1;
      gnt_log.push_back(m_gnt);
      lock_cyc.push_back(cyc);
    end
    for (int r = 0; r < N; r++) if (val[r] && rdy[r]) hd[r]++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (hd[r] < tl[r] && en_mask[r] && $urandom_range(99) < prob) begin
        val[r]         = 1'b1;
        data[r*W +: W] = sw_d[r][hd[r]];
        last[r]        = sw_l[r][hd[r]];
      end else begin
        val[r]         = 1'b0;
        data[r*W +: W] = $urandom;
        last[r]        = 1'($urandom_range(1));
      end
    end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while (!drained() && n < budget) begin
      drive();
      tick();
      n++;
    end
    chk("drain", 64'(drained()), 64'(1));
    drive();
    tick();
    drive();
    tick();
  endtask

  task automatic do_reset();
    arst    = 1'b1;
    val     = '0;
    last    = '0;
    s_valv  = '0;
    s_lastv = '0;
    #1;
    chk("rst_ready", 64'(rdy), 64'(0));
    chk("rst_val", 64'(rval), 64'(0));
    chk("rst_sum", 64'(rsum), 64'(0));
    chk("rst_id", 64'(rid), 64'(0));
    chk("rst_ssum", 64'(s_sum), 64'(0));
    m_locked = 0;
    m_ptr    = 0;
    m_gnt    = 0;
    m_total  = 0;
    m_sum    = 0;
    m_id     = 0;
    rq.delete();
    gnt_log.delete();
    lock_cyc.delete();
    p_sum.delete();
    p_id.delete();
    s_sums.delete();
    s_ids.delete();
    for (int r = 0; r < N; r++) begin
      hd[r] = 0;
      tl[r] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n, start, si, expv, r, len, cnt;
    logic [31:0] a, b, c, d;
    @(posedge clk);
    #1;
    do_reset();

    // three-word packet on requester 0
    push(0, 32'hFFFF_FFFF, 0);
    push(0, 32'h1, 0);
    push(0, 32'h0, 1);
    run(40);
    chk("s1_cnt", 64'(p_sum.size()), 64'(1));
    chk("s1_sum", 64'(p_sum[0]), 64'(33));
    chk("s1_id", 64'(p_id[0]), 64'(0));

    // two single-word packets contending
    do_reset();
    push(1, 32'hF0, 1);
    push(3, 32'h3, 1);
    run(40);
    chk("s2_g0", 64'(gnt_log[0]), 64'(1));
    chk("s2_g1", 64'(gnt_log[1]), 64'(3));
    chk("s2_sum0", 64'(p_sum[0]), 64'(4));
    chk("s2_id0", 64'(p_id[0]), 64'(1));
    chk("s2_sum1", 64'(p_sum[1]), 64'(2));
    chk("s2_id1", 64'(p_id[1]), 64'(3));

    // all requesters busy with 2-word packets
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int q = 0; q < N; q++) begin
        push(q, $urandom, 0);
        push(q, $urandom, 1);
      end
    end
    run(200);
    chk("s3_cnt", 64'(gnt_log.size()), 64'(12));
    for (int i = 0; i < 12; i++) begin
      chk("s3_order", 64'(gnt_log[i]), 64'(i % N));
    end
    for (int i = 0; i < 11; i++) begin
      chk("s3_gap", 64'(lock_cyc[i+1] - lock_cyc[i]), 64'(3));
    end
    for (int q = 0; q < N; q++) begin
      cnt = 0;
      foreach (gnt_log[i]) if (gnt_log[i] == q) cnt++;
      chk("s3_starve", 64'(cnt), 64'(3));
    end

    // stalled packet keeps its grant
    do_reset();
    a = $urandom;
    b = $urandom;
    c = $urandom;
    push(2, a, 0);
    push(2, b, 0);
    push(2, c, 1);
    en_mask = 4'b0100;
    n = 0;
    while (hd[2] < 1 && n < 10) begin
      drive();
      tick();
      n++;
    end
    chk("s4_first", 64'(hd[2]), 64'(1));
    push(0, $urandom, 0);
    push(0, $urandom, 1);
    en_mask = 4'b0001;
    drive();
    tick();
    drive();
    tick();
    en_mask = 4'b0101;
    run(60);
    en_mask = '1;
    expv = $countones(a) + $countones(b) + $countones(c);
    chk("s4_g0", 64'(gnt_log[0]), 64'(2));
    chk("s4_g1", 64'(gnt_log[1]), 64'(0));
    chk("s4_id", 64'(p_id[0]), 64'(2));
    chk("s4_sum", 64'(p_sum[0]), 64'(expv));

    // reset in the middle of a packet
    start = hd[0];
    for (int i = 0; i < 4; i++) push(0, 32'hFFFF_FFFF, i == 3);
    n = 0;
    while (hd[0] < start + 2 && n < 20) begin
      drive();
      tick();
      n++;
    end
    chk("s5_part", 64'(hd[0] - start), 64'(2));
    do_reset();
    push(1, 32'hFF, 1);
    run(40);
    chk("s5_cnt", 64'(p_sum.size()), 64'(1));
    chk("s5_sum", 64'(p_sum[0]), 64'(8));
    chk("s5_id", 64'(p_id[0]), 64'(1));

    // random packets with random valid gaps
    do_reset();
    prob = 60;
    for (int k = 0; k < 16; k++) begin
      r   = $urandom_range(N-1);
      len = $urandom_range(4, 1);
      for (int j = 0; j < len; j++) begin
        case ($urandom_range(3))
          0:       d = 32'h0;
          1:       d = 32'hFFFF_FFFF;
          default: d = $urandom;
        endcase
        push(r, d, j == len-1);
      end
    end
    run(1000);
    chk("rnd_cnt", 64'(p_sum.size()), 64'(16));
    prob = 100;

    // saturation on the two-word instance
    do_reset();
    si = 0;
    n  = 0;
    while (s_sums.size() < 1 && n < 40) begin
      s_valv[0]       = (si < 4);
      s_data[W-1:0]   = 32'hFFFF_FFFF;
      s_lastv[0]      = (si == 3);
      tick();
      if (s_hs) si++;
      n++;
    end
    chk("sat_cnt", 64'(s_sums.size()), 64'(1));
    chk("sat_sum", 64'(s_sums[0]), 64'(127));
    chk("sat_id", 64'(s_ids[0]), 64'(0));
    tick();
    chk("sat_hold", 64'(s_sum), 64'(127));
    si = 0;
    n  = 0;
    while (s_sums.size() < 2 && n < 40) begin
      s_valv[0]     = (si < 1);
      s_data[W-1:0] = 32'h1;
      s_lastv[0]    = 1'b1;
      tick();
      if (s_hs) si++;
      n++;
    end
    chk("sat_next_cnt", 64'(s_sums.size()), 64'(2));
    chk("sat_next", 64'(s_sums[1]), 64'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
